// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder with a 16-byte memory, clocked entirely by top_clk.
// Supports read data (0x03) and device-ID (0xAB). Other opcodes are swallowed until cs rises.
module spi_flash_responder #(
    parameter logic [7:0] DEVICE_ID = 8'h13,
    parameter logic       IDLE_MISO = 1'b1
) (
    input  logic       top_clk,
    input  logic       top_rst_n,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    output logic       load_rdy,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] last_opcode
);

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'hAB;

    typedef enum logic [2:0] {StIdle, StOpcode, StAddr, StData, StIgnore} state_e;

    // Synchronizers and edge detection
    logic cs_s1, cs_s2, cs_prev;
    logic sck_s1, sck_s2, sck_prev;
    logic mosi_s1, mosi_s2;
    logic [1:0] settle_q;
    logic armed_q;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_prev  <= 1'b1;
            sck_s1   <= 1'b0;
            sck_s2   <= 1'b0;
            sck_prev <= 1'b0;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            cs_s1    <= cs;
            cs_s2    <= cs_s1;
            cs_prev  <= cs_s2;
            sck_s1   <= sck;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            mosi_s1  <= mosi;
            mosi_s2  <= mosi_s1;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            // Starts are only accepted once cs has genuinely been seen high after reset.
            if (settle_q == 2'd2 && cs_s2 && cs_prev) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall;

    always_comb begin
        sck_rise = sck_s2 & ~sck_prev;
        sck_fall = ~sck_s2 & sck_prev;
        cs_rise  = cs_s2 & ~cs_prev;
        cs_fall  = armed_q & cs_prev & ~cs_s2;
    end

    // Memory: no reset, contents survive top_rst_n
    logic [7:0] mem [16];

    always_ff @(posedge top_clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // Transaction state
    state_e     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [3:0] ptr_q, ptr_d;
    logic       is_read_q, is_read_d;
    logic       miso_q, miso_d;
    logic       busy_q, busy_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] last_op_q, last_op_d;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 5'd0;
            tx_cnt_q    <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            ptr_q       <= 4'd0;
            is_read_q   <= 1'b0;
            miso_q      <= IDLE_MISO;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            last_op_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            is_read_q   <= is_read_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            last_op_q   <= last_op_d;
        end
    end

    logic [7:0] rx_shift;
    logic [3:0] ptr_next;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        is_read_d   = is_read_q;
        miso_d      = miso_q;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        last_op_d   = last_op_q;
        rx_shift    = {rx_q, mosi_s2};
        ptr_next    = ptr_q + 4'd1;

        // cs rise wins over any sck edge seen in the same cycle.
        if (cs_rise) begin
            state_d   = StIdle;
            bit_cnt_d = 5'd0;
            tx_cnt_d  = 3'd0;
            miso_d    = IDLE_MISO;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    miso_d = IDLE_MISO;
                    if (cs_fall) begin
                        state_d   = StOpcode;
                        bit_cnt_d = 5'd0;
                        busy_d    = 1'b1;
                    end
                end
                StOpcode: begin
                    if (sck_rise) begin
                        rx_d = rx_shift[6:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            last_op_d   = rx_shift;
                            cmd_valid_d = 1'b1;
                            is_read_d   = (rx_shift == OP_READ);
                            if (rx_shift == OP_READ || rx_shift == OP_RDID) begin
                                state_d = StAddr;
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        rx_d = rx_shift[6:0];
                        if (bit_cnt_q == 5'd23) begin
                            // Only the low nibble of the address matters for a 16-byte memory.
                            bit_cnt_d = 5'd0;
                            tx_cnt_d  = 3'd0;
                            ptr_d     = rx_shift[3:0];
                            tx_d      = is_read_q ? mem[rx_shift[3:0]] : DEVICE_ID;
                            state_d   = StData;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                StData: begin
                    if (sck_fall) begin
                        miso_d = tx_q[7];
                        if (tx_cnt_q == 3'd7) begin
                            tx_cnt_d = 3'd0;
                            if (is_read_q) begin
                                ptr_d = ptr_next;
                                tx_d  = mem[ptr_next];
                            end else begin
                                tx_d = DEVICE_ID;
                            end
                        end else begin
                            tx_cnt_d = tx_cnt_q + 3'd1;
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                StIgnore: begin
                    miso_d = IDLE_MISO;
                end
                default: begin
                    state_d = StIdle;
                    miso_d  = IDLE_MISO;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign miso        = miso_q;
    assign busy        = busy_q;
    assign load_rdy    = ~busy_q;
    assign cmd_valid   = cmd_valid_q;
    assign last_opcode = last_op_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized scoreboard bench for spi_flash_responder: an SPI master drives transactions,
// monitors compare opcode pulses and received miso bytes against a queue-based reference model.
module tb_spi_flash_responder;

    localparam logic [7:0] DEV_ID = 8'h13;

    logic       top_clk = 1'b0;
    logic       top_rst_n;
    logic       cs, sck, mosi;
    logic       miso;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       load_rdy, busy, cmd_valid;
    logic [7:0] last_opcode;

    spi_flash_responder #(
        .DEVICE_ID(DEV_ID),
        .IDLE_MISO(1'b1)
    ) dut (
        .top_clk    (top_clk),
        .top_rst_n  (top_rst_n),
        .cs         (cs),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_rdy   (load_rdy),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .last_opcode(last_opcode)
    );

    always #5 top_clk = ~top_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [16];
    logic [7:0] exp_bytes [$];
    logic [7:0] exp_ops [$];
    bit phase_data = 1'b0;
    bit mon_off = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge top_clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(5);
        sck = 1'b1;
        tick(5);
        sck = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        phase_data = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic load_mem(input logic [3:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        tick(1);
        load_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // One SPI transaction; abort_at < 0 means run to completion, otherwise cs rises after that
    // many bits. busy_load fires a write while busy (must be dropped). coincide puts a write
    // in the cs-fall detect cycle (must land).
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                           input int abort_at, input bit busy_load, input bit coincide,
                           input logic [3:0] co_addr, input logic [7:0] co_data);
        int sent;
        logic [3:0] idx;
        sent = 0;
        if (coincide) begin
            cs = 1'b0;
            tick(2);
            load_mem(co_addr, co_data);
            tick(1);
        end else begin
            cs_low();
        end
        if (busy_load) begin
            check("busy_in_txn", busy, 1);
            check("load_rdy_in_txn", load_rdy, 0);
            load_addr = 4'($urandom);
            load_data = 8'($urandom);
            load_en   = 1'b1;
            tick(1);
            load_en   = 1'b0;
        end
        for (int i = 7; i >= 0; i--) begin
            if (sent == abort_at) break;
            if (i == 0) exp_ops.push_back(op);
            send_bit(op[i]);
            sent++;
        end
        if (sent == 8 && (op == 8'h03 || op == 8'hAB)) begin
            for (int i = 23; i >= 0; i--) begin
                if (sent == abort_at) break;
                send_bit(addr[i]);
                sent++;
            end
            if (sent == 32) begin
                for (int b = 0; b < nbytes; b++) begin
                    idx = addr[3:0] + b[3:0];
                    exp_bytes.push_back((op == 8'h03) ? model_mem[idx] : DEV_ID);
                end
                phase_data = 1'b1;
                for (int k = 0; k < nbytes * 8; k++) send_bit(1'($urandom));
            end
        end else if (sent == 8) begin
            for (int k = 0; k < nbytes * 8; k++) send_bit(1'($urandom));
        end
        if (abort_at < 0) check("busy_before_cs_rise", busy, 1);
        cs_high();
        check("busy_after_cs_rise", busy, 0);
        check("miso_after_cs_rise", miso, 1);
    endtask

    // Opcode monitor
    always @(negedge top_clk) begin
        if (cmd_valid === 1'b1) begin
            if (exp_ops.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL cmd_valid: unexpected pulse, last_opcode %0h", last_opcode);
            end else begin
                check("last_opcode_on_cmd_valid", last_opcode, exp_ops.pop_front());
            end
        end
    end

    // miso monitor: master samples just before each sck rise
    logic [7:0] rx_byte = 8'h00;
    int rx_bits = 0;
    always @(posedge sck) begin
        if (!mon_off) begin
            if (phase_data) begin
                rx_byte = {rx_byte[6:0], miso};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_bits = 0;
                    if (exp_bytes.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL miso_byte: got %0h with no byte expected", rx_byte);
                    end else begin
                        check("miso_byte", rx_byte, exp_bytes.pop_front());
                    end
                end
            end else begin
                check("miso_idle", miso, 1);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int r;
        top_rst_n = 1'b0;
        cs = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        load_en = 1'b0;
        load_addr = 4'd0;
        load_data = 8'd0;
        tick(4);
        check("rst_miso", miso, 1);
        check("rst_busy", busy, 0);
        check("rst_load_rdy", load_rdy, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_last_opcode", last_opcode, 8'h00);
        top_rst_n = 1'b1;
        tick(6);

        // Device ID
        run_txn(8'hAB, 24'h000000, 1, -1, 1'b0, 1'b0, 4'd0, 8'd0);
        check("last_opcode_ab", last_opcode, 8'hAB);

        // Read with increment
        load_mem(4'd5, 8'hC3);
        load_mem(4'd6, 8'h3C);
        run_txn(8'h03, 24'h000005, 2, -1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Read wrapping 15 -> 0
        load_mem(4'd15, 8'hA5);
        load_mem(4'd0, 8'h5A);
        run_txn(8'h03, 24'h00000F, 2, -1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Unsupported opcode
        run_txn(8'h55, 24'h000000, 2, -1, 1'b0, 1'b0, 4'd0, 8'd0);
        check("last_opcode_55", last_opcode, 8'h55);

        // Abort after 10 address bits, then clean device ID
        run_txn(8'h03, 24'hFFFFFF, 0, 18, 1'b0, 1'b0, 4'd0, 8'd0);
        run_txn(8'hAB, 24'h123456, 2, -1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Load in the cs-fall detect cycle lands, then is read back
        run_txn(8'h03, 24'hABCDE9, 1, -1, 1'b0, 1'b1, 4'd9, 8'h77);

        // Load while busy is dropped
        run_txn(8'hAB, 24'h000000, 1, -1, 1'b1, 1'b0, 4'd0, 8'd0);
        run_txn(8'h03, 24'h000005, 1, -1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Reset mid-DATA
        cs_low();
        exp_ops.push_back(8'h03);
        for (int i = 7; i >= 0; i--) send_bit(op_read_bit(i));
        for (int i = 0; i < 24; i++) send_bit(1'b0);
        mon_off = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        tick(2);
        top_rst_n = 1'b0;
        #1;
        check("midrst_miso", miso, 1);
        check("midrst_busy", busy, 0);
        check("midrst_last_opcode", last_opcode, 8'h00);
        check("midrst_load_rdy", load_rdy, 1);
        check("midrst_cmd_valid", cmd_valid, 0);
        tick(3);
        top_rst_n = 1'b1;
        tick(10);
        check("cs_low_at_release_busy", busy, 0);
        mon_off = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        check("no_start_busy", busy, 0);
        check("no_start_last_opcode", last_opcode, 8'h00);
        cs = 1'b1;
        tick(10);
        run_txn(8'hAB, 24'h000000, 1, -1, 1'b0, 1'b0, 4'd0, 8'd0);

        // Randomized traffic
        for (int a = 0; a < 16; a++) load_mem(a[3:0], 8'($urandom));
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 3);
            if (r <= 1) op = 8'h03;
            else if (r == 2) op = 8'hAB;
            else begin
                op = 8'($urandom);
                if (op == 8'h03 || op == 8'hAB) op = 8'h9F;
            end
            if ($urandom_range(0, 3) == 0) load_mem(4'($urandom), 8'($urandom));
            run_txn(op, 24'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 31) : -1,
                    1'($urandom), 1'b0, 4'd0, 8'd0);
        end

        tick(10);
        check("bytes_left", exp_bytes.size(), 0);
        check("ops_left", exp_ops.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic op_read_bit(input int i);
        logic [7:0] v;
        v = 8'h03;
        return v[i];
    endfunction

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 The module SHALL have parameter DEVICE_ID, default 8'h13: byte returned for opcode 0xAB.
REQ-002 The module SHALL have parameter IDLE_MISO, default 1'b1: MISO level whenever no data bit is being driven.
REQ-003 top_clk  input  1  sole system clock; all state is updated on its rising edge.
REQ-004 top_rst_n  input  1  asynchronous, active-low reset.
REQ-005 cs  input  1  SPI chip select, active low, asynchronous to top_clk.
REQ-006 sck  input  1  SPI clock, mode 0, asynchronous to top_clk, frequency <= top_clk/4.
REQ-007 mosi  input  1  SPI data in, MSB first.
REQ-008 miso  output  1  SPI data out, MSB first.
REQ-009 load_en  input  1  memory write strobe, one top_clk cycle per byte.
REQ-010 load_addr  input  4  memory write address.
REQ-011 load_data  input  8  memory write data.
REQ-012 load_rdy  output  1  high when load_en is accepted; equals NOT busy.
REQ-013 busy  output  1  high while a transaction is in progress (cs low, synchronized).
REQ-014 cmd_valid  output  1  one-cycle pulse when an opcode byte completes.
REQ-015 last_opcode  output  8  most recently completed opcode byte.

Function
REQ-016 cs, sck and mosi SHALL each pass through a 2-flop synchronizer; an sck rise or fall SHALL be detected by comparing the synchronized value with its previous-cycle value.
REQ-017 The state machine SHALL have the states IDLE, OPCODE, ADDR, DATA and IGNORE.
REQ-018 IDLE -> OPCODE when the synchronized cs falls; the bit counter clears and busy goes to 1.
REQ-019 Synchronized mosi SHALL be shifted into the receive register on each detected sck rise, and never on a fall.
REQ-020 On the 8th rise in OPCODE, the module SHALL update last_opcode, pulse cmd_valid for one cycle, and go to ADDR for 0x03 or 0xAB, or to IGNORE for any other opcode.
REQ-021 ADDR SHALL collect 24 bits; for 0x03 the low 4 bits of the address load the read pointer (bits 23:4 ignored), and for 0xAB the 24 bits are dummy.
REQ-022 The 24th rise in ADDR SHALL move the machine to DATA, and the transmit register SHALL load mem[pointer] for 0x03 or DEVICE_ID for 0xAB.
REQ-023 In DATA, miso SHALL change only on a detected sck fall: the first fall drives bit 7, and each later fall drives the next lower bit.
REQ-024 After bit 0 has been driven, the next fall SHALL drive bit 7 of the next byte: for 0x03 the pointer increments modulo 16 (15 wraps to 0), and for 0xAB DEVICE_ID repeats.
REQ-025 miso SHALL equal IDLE_MISO in IDLE, OPCODE, ADDR and IGNORE.
REQ-026 IGNORE SHALL discard all sck edges until cs rises.
REQ-027 A synchronized cs rise in any state SHALL, in the next cycle, return the machine to IDLE, clear the bit counter, set miso to IDLE_MISO and clear busy; a partial byte is discarded.
REQ-028 If cs rises and an sck edge occurs in the same cycle, the cs rise SHALL take priority and the edge SHALL be ignored.
REQ-029 The memory SHALL be 16 x 8 bits; load_en while busy=0 SHALL write load_data to load_addr, and load_en while busy=1 SHALL be ignored with no write.
REQ-030 If a load coincides with the cs-fall detect cycle, the load SHALL complete and busy SHALL rise in the next cycle.
REQ-031 Latency from an sck fall at the pin to the miso change SHALL be at most 4 top_clk cycles.

Reset
REQ-032 While top_rst_n = 0, the outputs SHALL be: state = IDLE, miso = IDLE_MISO, busy = 0, load_rdy = 1, cmd_valid = 0, last_opcode = 8'h00, and all synchronizer flops = 1 for cs and 0 for sck and mosi.
REQ-033 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-transaction SHALL take effect immediately; after release, the module SHALL wait for a fresh cs fall, so a cs already low at release is not treated as a start.

Verification
REQ-035 Opcode 0xAB + 3x 0x00, then 8 more sck -> miso bits 0x13 MSB first; cmd_valid pulses once; last_opcode = 0xAB.
REQ-036 Load mem[5] = 0xC3 and mem[6] = 0x3C; send 0x03 + address 0x000005, then 16 sck -> bytes 0xC3 then 0x3C.
REQ-037 Load mem[15] = 0xA5 and mem[0] = 0x5A; send 0x03 + address 0x00000F, then 16 sck -> 0xA5, 0x5A (wrap).
REQ-038 Opcode 0x55 then 16 sck -> miso constantly 1; last_opcode = 0x55; busy until cs high.
REQ-039 cs raised after 10 address bits, then a full 0xAB transaction -> correct 0x13; no stale bits.
REQ-040 top_rst_n pulsed low mid-DATA -> miso = 1 within the reset cycle, busy = 0, last_opcode = 0x00; load_en during busy = 1 -> memory unchanged.
